dense_classifier_argmax_top: RTL and testbench
==============================================

DENSE_CLASSIFIER_ARGMAX_TOP -- requirements
Module: dense_classifier_argmax_top

Interface
REQ-001: Parameter IN_LEN, default 512, number of 4-bit pooled activations per inference.
REQ-002: Parameter NUM_CLASSES, default 9, number of output classes (max 16).
REQ-003: Parameter ACC_W, default 24, signed accumulator width.
REQ-004: clk  in  1  single clock; all flops on rising edge.
REQ-005: resetn  in  1  reset, asynchronous and active-low.
REQ-006: start  in  1  one-cycle request to run one inference.
REQ-007: pool_start  out  1  one-cycle launch pulse to the upstream max-pool stage.
REQ-008: pool_done  in  1  upstream stage finished; pooled data readable.
REQ-009: pool_read_addr  out  32  activation index into the upstream output; data arrives 1 cycle later.
REQ-010: pool_read_data  in  4  unsigned activation.
REQ-011: w_addr  out  16  weight ROM address = class*IN_LEN + index; data arrives 1 cycle later.
REQ-012: w_data  in  8  signed weight.
REQ-013: bias_addr  out  4  bias ROM address = class; data arrives 1 cycle later.
REQ-014: bias_data  in  16  signed bias, sign-extended to ACC_W.
REQ-015: busy  out  1  high in every state except IDLE.
REQ-016: done  out  1  one-cycle pulse when a result is ready.
REQ-017: class_id  out  4  index of the winning class.
REQ-018: class_score  out  ACC_W  signed score of the winning class.

Function
REQ-019: FSM states are IDLE, POOL_START, WAIT_POOL, BIAS, MAC, CMP and DONE_ST.
REQ-020: IDLE -> POOL_START on start=1; POOL_START drives pool_start=1 for exactly one cycle, then enters WAIT_POOL.
REQ-021: WAIT_POOL holds until pool_done=1, then clears the class counter, sets best_score to the most negative ACC_W value and best_id to 0, and enters BIAS.
REQ-022: BIAS drives bias_addr=class for one cycle, clears the index counter, and enters MAC.
REQ-023: MAC lasts IN_LEN+1 cycles; in cycles 1..IN_LEN it issues pool_read_addr=index and w_addr=class*IN_LEN+index with index 0..IN_LEN-1.
REQ-024: MAC cycle 1 loads acc with sign-extended bias_data; MAC cycles 2..IN_LEN+1 add signed(w_data)*unsigned(pool_read_data), giving a 13-bit signed product.
REQ-025: Products and accumulation never overflow at the default parameters (|sum| < 2^23); the accumulator wraps and does not saturate.
REQ-026: CMP replaces best_score/best_id only when acc > best_score, so a tie keeps the lower class index; CMP then enters BIAS for the next class, or DONE_ST after class NUM_CLASSES-1.
REQ-027: DONE_ST loads class_id/class_score from best_id/best_score, pulses done for one cycle, and enters IDLE.
REQ-028: done rises exactly NUM_CLASSES*(IN_LEN+3)+1 rising edges after the edge that samples pool_done=1.
REQ-029: class_id and class_score hold their values until the next DONE_ST.
REQ-030: start is ignored while busy=1; pool_done is ignored outside WAIT_POOL.
REQ-031: Address outputs hold their last value when not issuing.

Reset
REQ-032: resetn=0 asynchronously forces state IDLE and clears every output (pool_start, done, busy, pool_read_addr, w_addr, bias_addr, class_id, class_score) and every internal counter and accumulator to 0.
REQ-033: Reset mid-inference abandons the run; no done pulse follows; the first start after release begins a fresh run.

Verification
REQ-034: IN_LEN=4, NUM_CLASSES=2, all activations 15, weights class0=+1 and class1=+2, biases 0 -> class_id=1, class_score=120, done on edge 15 after pool_done is sampled.
REQ-035: All weights 0, biases {5,5,3,...} -> tie between classes 0 and 1 -> class_id=0, class_score=5.
REQ-036: All weights -128, activations 15, biases 0, default parameters -> class_score=-983040 with no wrap, class_id=0.
REQ-037: start pulsed during MAC -> no second pool_start, and exactly one done pulse.
REQ-038: resetn dropped during MAC of class 3 -> all outputs 0 immediately; a restart produces correct results with no stale accumulation.
REQ-039: pool_done held high for 10 cycles and start pulsed twice back-to-back -> exactly one pool_start per accepted start, and address sequences 0..IN_LEN-1 per class in order.

Source files
------------

// File: rtl/dense_classifier_argmax_top.sv
// Dense classifier: per-class bias + MAC over pooled activations,
// followed by a running argmax across all classes.
module dense_classifier_argmax_top #(
  parameter int IN_LEN      = 512,
  parameter int NUM_CLASSES = 9,
  parameter int ACC_W       = 24
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    pool_start,
  input  logic                    pool_done,
  output logic [31:0]             pool_read_addr,
  input  logic [3:0]              pool_read_data,
  output logic [15:0]             w_addr,
  input  logic [7:0]              w_data,
  output logic [3:0]              bias_addr,
  input  logic [15:0]             bias_data,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_id,
  output logic signed [ACC_W-1:0] class_score
);

  localparam int CNT_W = $clog2(IN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_LEN);
  localparam logic [3:0] LAST_CLS = 4'(NUM_CLASSES - 1);
  localparam logic [15:0] LEN16 = 16'(IN_LEN);
  localparam logic signed [ACC_W-1:0] MIN_SCORE =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, POOL_START, WAIT_POOL, BIAS, MAC, CMP, DONE_ST
  } state_t;

  state_t state_q, state_d;

  logic [3:0]              cls_q, cls_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic [3:0]              best_id_q, best_id_d;
  logic [31:0]             rd_addr_q, rd_addr_d;
  logic [15:0]             w_addr_q, w_addr_d;
  logic [3:0]              b_addr_q, b_addr_d;
  logic                    done_q, done_d;
  logic [3:0]              cid_q, cid_d;
  logic signed [ACC_W-1:0] cscore_q, cscore_d;

  logic [CNT_W-1:0]  nxt_idx;
  logic signed [12:0] prod;

  assign nxt_idx = idx_q + CNT_W'(1);
  assign prod = 13'($signed(w_data)) *
                13'($signed({1'b0, pool_read_data}));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = POOL_START;
      POOL_START: state_d = WAIT_POOL;
      WAIT_POOL:  if (pool_done) state_d = BIAS;
      BIAS:       state_d = MAC;
      MAC:        if (idx_q == LAST_IDX) state_d = CMP;
      CMP:        state_d = (cls_q == LAST_CLS) ? DONE_ST : BIAS;
      DONE_ST:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pool_start = (state_q == POOL_START);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    cls_d     = cls_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    best_d    = best_q;
    best_id_d = best_id_q;
    rd_addr_d = rd_addr_q;
    w_addr_d  = w_addr_q;
    b_addr_d  = b_addr_q;
    done_d    = 1'b0;
    cid_d     = cid_q;
    cscore_d  = cscore_q;
    unique case (state_q)
      WAIT_POOL: if (pool_done) begin
        cls_d     = 4'd0;
        best_d    = MIN_SCORE;
        best_id_d = 4'd0;
        b_addr_d  = 4'd0;
      end
      BIAS: begin
        idx_d     = '0;
        rd_addr_d = 32'd0;
        w_addr_d  = 16'(cls_q) * LEN16;
      end
      MAC: begin
        // Read data lags the address by one cycle, so the
        // first MAC cycle consumes the bias instead of a product.
        if (idx_q == '0) acc_d = ACC_W'($signed(bias_data));
        else             acc_d = acc_q + ACC_W'(prod);
        if (idx_q != LAST_IDX) idx_d = nxt_idx;
        if (nxt_idx < LAST_IDX) begin
          rd_addr_d = 32'(nxt_idx);
          w_addr_d  = 16'(cls_q) * LEN16 + 16'(nxt_idx);
        end
      end
      CMP: begin
        if (acc_q > best_q) begin
          best_d    = acc_q;
          best_id_d = cls_q;
        end
        if (cls_q != LAST_CLS) begin
          cls_d    = cls_q + 4'd1;
          b_addr_d = cls_q + 4'd1;
        end
      end
      DONE_ST: begin
        done_d   = 1'b1;
        cid_d    = best_id_q;
        cscore_d = best_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cls_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      best_q    <= '0;
      best_id_q <= '0;
      rd_addr_q <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      done_q    <= 1'b0;
      cid_q     <= '0;
      cscore_q  <= '0;
    end else begin
      cls_q     <= cls_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
      best_id_q <= best_id_d;
      rd_addr_q <= rd_addr_d;
      w_addr_q  <= w_addr_d;
      b_addr_q  <= b_addr_d;
      done_q    <= done_d;
      cid_q     <= cid_d;
      cscore_q  <= cscore_d;
    end
  end

  assign pool_read_addr = rd_addr_q;
  assign w_addr         = w_addr_q;
  assign bias_addr      = b_addr_q;
  assign done           = done_q;
  assign class_id       = cid_q;
  assign class_score    = cscore_q;

endmodule

// File: tb/tb_dense_classifier_argmax_top.sv
// Bench for dense_classifier_argmax_top: small (4x2) and default
// instances, directed table plus random runs against a reference model.
module tb_dense_classifier_argmax_top;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic pdone = 1'b0;
  bit   sel = 1'b0;

  logic ps_s, ps_b, dn_s, dn_b, bz_s, bz_b;
  logic [31:0] pra_s, pra_b;
  logic [15:0] wa_s, wa_b;
  logic [3:0]  ba_s, ba_b, cid_s, cid_b;
  logic signed [23:0] sc_s, sc_b;
  logic [3:0]  a_s, a_b;
  logic [7:0]  w_s, w_b;
  logic [15:0] b_s, b_b;

  logic signed [7:0]  wmem [0:4607];
  logic [3:0]         amem [0:511];
  logic signed [15:0] bmem [0:15];

  wire unused_hi = ^{pra_s[31:9], pra_b[31:9], wa_s[15:13], wa_b[15:13]};

  always #5 clk = ~clk;

  dense_classifier_argmax_top #(
    .IN_LEN(4), .NUM_CLASSES(2), .ACC_W(24)
  ) u_s (
    .clk(clk), .resetn(resetn), .start(start & ~sel),
    .pool_start(ps_s), .pool_done(pdone & ~sel),
    .pool_read_addr(pra_s), .pool_read_data(a_s),
    .w_addr(wa_s), .w_data(w_s),
    .bias_addr(ba_s), .bias_data(b_s),
    .busy(bz_s), .done(dn_s),
    .class_id(cid_s), .class_score(sc_s)
  );

  dense_classifier_argmax_top u_b (
    .clk(clk), .resetn(resetn), .start(start & sel),
    .pool_start(ps_b), .pool_done(pdone & sel),
    .pool_read_addr(pra_b), .pool_read_data(a_b),
    .w_addr(wa_b), .w_data(w_b),
    .bias_addr(ba_b), .bias_data(b_b),
    .busy(bz_b), .done(dn_b),
    .class_id(cid_b), .class_score(sc_b)
  );

  // ROMs and the pool buffer answer one cycle after the address
  always @(posedge clk) begin
    w_s <= wmem[wa_s[12:0]];
    a_s <= amem[pra_s[8:0]];
    b_s <= bmem[ba_s];
    w_b <= wmem[wa_b[12:0]];
    a_b <= amem[pra_b[8:0]];
    b_b <= bmem[ba_b];
  end

  wire        ps  = sel ? ps_b : ps_s;
  wire        dn  = sel ? dn_b : dn_s;
  wire        bz  = sel ? bz_b : bz_s;
  wire [31:0] pra = sel ? pra_b : pra_s;
  wire [15:0] wa  = sel ? wa_b : wa_s;
  wire [3:0]  ba  = sel ? ba_b : ba_s;
  wire [3:0]  cid = sel ? cid_b : cid_s;
  wire signed [23:0] sc = sel ? sc_b : sc_s;

  int ps_cnt = 0;
  int dn_cnt = 0;
  logic [15:0] prev_w = '0;
  logic [31:0] prev_r = '0;
  logic [15:0] wq[$];
  logic [31:0] rq[$];

  always @(negedge clk) begin
    if (ps) ps_cnt <= ps_cnt + 1;
    if (dn) dn_cnt <= dn_cnt + 1;
    if (wa_s != prev_w) begin
      wq.push_back(wa_s);
      prev_w <= wa_s;
    end
    if (pra_s != prev_r) begin
      rq.push_back(pra_s);
      prev_r <= pra_s;
    end
  end

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void model(input int len, input int nc,
                                output logic [3:0] id,
                                output logic signed [23:0] score);
    longint s;
    logic signed [23:0] t;
    id = 4'd0;
    score = '0;
    for (int c = 0; c < nc; c++) begin
      s = longint'(bmem[c]);
      for (int i = 0; i < len; i++)
        s += longint'(wmem[c*len+i]) * longint'(amem[i]);
      t = s[23:0];
      if (c == 0 || t > score) begin
        score = t;
        id = 4'(c);
      end
    end
  endfunction

  task automatic rand_mem();
    foreach (wmem[i]) wmem[i] = 8'($urandom);
    foreach (amem[i]) amem[i] = 4'($urandom);
    foreach (bmem[i]) bmem[i] = 16'($urandom);
  endtask

  task automatic run(input int hold, input bit twice, input int mid,
                     output logic [3:0] id,
                     output logic signed [23:0] score);
    int len, nc, ps0, dn0, k, wb, rb, k0;
    logic [15:0] w0s;
    logic [31:0] r0s;
    bit got;
    len = sel ? 512 : 4;
    nc = sel ? 9 : 2;
    @(negedge clk);
    ps0 = ps_cnt; dn0 = dn_cnt;
    wb = wq.size(); rb = rq.size();
    w0s = wa_s; r0s = pra_s;
    start = 1'b1;
    @(negedge clk);
    chk("pool_start", ps, 1);
    start = twice;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    pdone = 1'b1;
    @(posedge clk);
    k = 0; got = 1'b0;
    while (k < nc * (len + 3) + 20) begin
      @(negedge clk);
      if (k + 1 >= hold) pdone = 1'b0;
      start = (mid != 0 && k == mid);
      if (dn) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      k++;
    end
    pdone = 1'b0;
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("latency", k, nc * (len + 3) + 1);
    repeat (20) @(negedge clk);
    chk("pool_start_count", ps_cnt - ps0, 1);
    chk("done_count", dn_cnt - dn0, 1);
    chk("busy_after", bz, 0);
    id = cid;
    score = sc;
    if (!sel) begin
      k0 = (w0s == 16'd0) ? 1 : 0;
      chk("waddr_count", wq.size() - wb, 2 * len - k0);
      for (int e = k0; e < 2 * len; e++)
        if (wb + e - k0 < wq.size())
          chk("waddr_seq", wq[wb+e-k0], e);
      k0 = (r0s == 32'd0) ? 1 : 0;
      chk("raddr_count", rq.size() - rb, 2 * len - k0);
      for (int e = k0; e < 2 * len; e++)
        if (rb + e - k0 < rq.size())
          chk("raddr_seq", rq[rb+e-k0], e % len);
    end
  endtask

  typedef struct {
    bit big;
    int w0, w1, act, b0, b1;
    int hold, twice, mid;
    int eid, esc;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [3:0] id, mid_;
    logic signed [23:0] score, msc;
    int len, nc, dn0;

    vt[0] = '{0, 1, 2, 15, 0, 0, 1, 0, 0, 1, 120};
    vt[1] = '{0, 0, 0, 7, 5, 5, 1, 0, 0, 0, 5};
    vt[2] = '{1, -128, -128, 15, 0, 0, 1, 0, 0, 0, -983040};
    vt[3] = '{0, -1, -1, 3, -10, -20, 1, 0, 0, 0, -22};
    vt[4] = '{0, 3, -2, 9, 100, 50, 10, 1, 0, 0, 208};
    vt[5] = '{0, -5, 4, 2, 0, 0, 1, 0, 5, 1, 32};

    #1;
    chk("rst_pool_start", ps_s, 0);
    chk("rst_done", dn_s, 0);
    chk("rst_busy", bz_s, 0);
    chk("rst_raddr", pra_s, 0);
    chk("rst_waddr", wa_s, 0);
    chk("rst_baddr", ba_s, 0);
    chk("rst_class_id", cid_s, 0);
    chk("rst_score", sc_s, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      sel = vt[v].big;
      len = sel ? 512 : 4;
      nc = sel ? 9 : 2;
      for (int c = 0; c < 16; c++)
        bmem[c] = 16'(c == 0 ? vt[v].b0 : vt[v].b1);
      for (int i = 0; i < len; i++) begin
        amem[i] = 4'(vt[v].act);
        for (int c = 0; c < nc; c++)
          wmem[c*len+i] = 8'(c == 0 ? vt[v].w0 : vt[v].w1);
      end
      run(vt[v].hold, vt[v].twice[0], vt[v].mid, id, score);
      chk($sformatf("vec%0d_class_id", v), id, vt[v].eid);
      chk($sformatf("vec%0d_score", v), score, vt[v].esc);
    end

    sel = 1'b0;
    for (int r = 0; r < 6; r++) begin
      rand_mem();
      model(4, 2, mid_, msc);
      run(1 + (r % 3), r[0], 0, id, score);
      chk("rand_class_id", id, mid_);
      chk("rand_score", score, msc);
    end

    // abandon a default-size run mid-MAC of class 3
    sel = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r38_pool_start", ps, 1);
    @(negedge clk);
    pdone = 1'b1;
    @(negedge clk);
    pdone = 1'b0;
    repeat (1556) @(negedge clk);
    chk("r38_busy_before", bz, 1);
    #2 resetn = 1'b0;
    #1;
    chk("r38_pool_start", ps_b, 0);
    chk("r38_done", dn_b, 0);
    chk("r38_busy", bz_b, 0);
    chk("r38_raddr", pra_b, 0);
    chk("r38_waddr", wa_b, 0);
    chk("r38_baddr", ba_b, 0);
    chk("r38_class_id", cid_b, 0);
    chk("r38_score", sc_b, 0);
    dn0 = dn_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("r38_no_done", dn_cnt - dn0, 0);
    rand_mem();
    model(512, 9, mid_, msc);
    run(1, 1'b0, 0, id, score);
    chk("r38_restart_id", id, mid_);
    chk("r38_restart_score", score, msc);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
